// File: rtl/div_ctrl_if.sv
// Divider handshake bundle between the EX stage (master) and div_ctrl (slave).
// Operands and controls flow in; {remainder,quotient}, ready and stall flow out.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   start_i;
    logic                   signed_i;
    logic                   annul_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   stall_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, result {rem,quo} valid
// on a one-cycle ready pulse WIDTH+1 cycles after accept (2 for divide-by-zero); stalls EX meanwhile.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sgn_q, sgn_d;
    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 accept;
    logic [WIDTH-1:0]     op1_abs;
    logic [WIDTH-1:0]     op2_abs;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_sub;
    logic                 rem_ge;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic                 stall;
    logic                 ready;

    assign accept  = bus.start_i & ~bus.annul_i;
    assign op1_abs = (bus.signed_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = (bus.signed_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // The bit shifted out of R takes part in the compare so divisors above 2**(WIDTH-1) stay exact.
    assign rem_sh  = {r_q, q_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, d_q};
    assign rem_ge  = rem_sh >= {1'b0, d_q};

    assign q_fix = (sgn_q & (s1_q ^ s2_q)) ? -q_q : q_q;
    assign r_fix = (sgn_q & s1_q) ? -r_q : r_q;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        result_d = result_q;
        stall    = 1'b0;
        ready    = 1'b0;

        case (state_q)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    cnt_d = '0;
                    if (bus.opdata2_i == '0) begin
                        // Divide-by-zero result is the raw dividend and all-ones, never sign-fixed.
                        state_d = BYZERO;
                        r_d     = bus.opdata1_i;
                        q_d     = '1;
                        d_d     = '0;
                        sgn_d   = 1'b0;
                        s1_d    = 1'b0;
                        s2_d    = 1'b0;
                    end else begin
                        state_d = ON;
                        r_d     = '0;
                        q_d     = op1_abs;
                        d_d     = op2_abs;
                        sgn_d   = bus.signed_i;
                        s1_d    = bus.opdata1_i[WIDTH-1];
                        s2_d    = bus.opdata2_i[WIDTH-1];
                    end
                end
            end

            ON: begin
                stall = ~bus.annul_i;
                if (bus.annul_i) begin
                    state_d = IDLE;
                end else begin
                    if (rem_ge) begin
                        r_d = rem_sub[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d = rem_sh[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = END;
                    end
                end
            end

            BYZERO: begin
                stall   = ~bus.annul_i;
                state_d = bus.annul_i ? IDLE : END;
            end

            END: begin
                // Result is committed here; a late flush cannot retract it.
                ready    = 1'b1;
                result_d = {r_fix, q_fix};
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result_q <= result_d;
        end
    end

    assign bus.result_o = (state_q == END) ? {r_fix, q_fix} : result_q;
    assign bus.ready_o  = ready;
    assign bus.stall_o  = stall;

endmodule
